fpu_pipe_retire: RTL and testbench
==================================

Name: fpu_pipe_retire

Overview:
Retire/tracking stage placed directly downstream of the fixed-latency FP add/sub pipes (fsub/fadd, NSTAGE=2).
- Those pipes have no valid or stall; this block owns the issue handshake.
- It tracks a tag alongside each in-flight operation and captures pipe_y/pipe_ovf exactly LATENCY cycles after issue.
- It buffers captured results in a small FIFO and presents them on a ready/valid output toward writeback.
- Credit-based issue throttling guarantees that no result leaving the pipe is ever dropped.

Parameters:
LATENCY, 2, cycles from issue edge to pipe result valid; must equal the pipe's NSTAGE.
TAGW, 5, width of the destination tag carried with each operation.
DEPTH, 4, result FIFO entries; also the maximum in-flight plus buffered operations.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high (integrator drives the pipe's rstn with ~rst)
in_valid  in  1  issue request; operands are on the pipe's x1/x2 this cycle
in_ready  out  1  issue accepted when in_valid&&in_ready
in_tag  in  TAGW  destination tag of the issued operation
pipe_y  in  32  result from the add/sub pipe
pipe_ovf  in  1  overflow/underflow flag from the pipe
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_data  out  32  result value
out_ovf  out  1  flag for the result
out_tag  out  TAGW  tag for the result
ovf_sticky  out  1  sticky flag (see Optional Feature)
ovf_clr  in  1  clears ovf_sticky

Behaviour:
- Reset state: all outputs and internal state are 0. After rst deasserts, in_ready=1.
- Issue:
  - accept = in_valid && in_ready.
  - On accept at the edge ending cycle t: vld_sr[0]<=1 and tag_sr[0]<=in_tag.
  - Both shift registers shift by one position every cycle, LATENCY entries deep.
- Capture:
  - In cycle t+LATENCY, vld_sr[LATENCY-1]=1.
  - At that cycle's edge, {pipe_ovf, tag_sr[LATENCY-1], pipe_y} is pushed into the FIFO.
  - pipe_y is sampled only in that cycle.
- Latency:
  - Accept in cycle t gives out_valid=1 in cycle t+LATENCY+1, with an empty FIFO and regardless of out_ready.
  - Throughput is 1 per cycle sustained when out_ready=1.
- Credit:
  - inflight = popcount(vld_sr). occ = inflight + fifo_count.
  - in_ready = (occ < DEPTH), computed combinationally from registered state only. It does not depend on in_valid or out_ready in the same cycle.
- Output:
  - out_* is the FIFO head, registered.
  - pop = out_valid && out_ready.
  - out_* holds stable while out_valid && !out_ready.
- FIFO boundaries:
  - Push and pop in the same cycle when full: both occur, and count is unchanged.
  - Push and pop in the same cycle when empty is impossible; a push to an empty FIFO appears next cycle.
  - Overflow is impossible by credit. An assertion fires on push while full.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. DEPTH must be a power of 2.
- Ordering: results retire in strict issue order.
- Reset mid-operation:
  - vld_sr, the FIFO, and the counts clear.
  - Pipe results already in flight are discarded and never pushed.
  - out_valid=0 on the cycle after the rst edge.

Optional Feature:
Macro FPU_RETIRE_STICKY_OVF_EN.
- Defined:
  - ovf_sticky sets on pop of an entry with out_ovf=1.
  - It clears on ovf_clr or rst.
  - If ovf_clr and a setting pop coincide, the set wins.
- Undefined: ovf_sticky is tied 0, ovf_clr is ignored, and no register is inferred.

Decomposition:
- Shared package fpu_pkg:
  - FLEN=32
  - FPU_ADDSUB_LATENCY=2 (the single source for both the pipe NSTAGE and LATENCY)
  - FPU_TAGW=5
  - typedef fpu_result_t {ovf, tag, data}
- Sub-module fpu_retire_fifo: synchronous FIFO parameterized by width and DEPTH, with push/pop/full/empty/count. The tracking shift register and credit logic stay in the top level.

Test Plan:
- Single op: fsub x1=0x40400000 (3.0), x2=0x3F800000 (1.0), in_tag=3, accepted in cycle 10, out_ready=1 -> cycle 13: out_valid=1, out_data=0x40000000, out_tag=3, out_ovf=0, and out_valid falls in cycle 14.
- Back-to-back: 8 consecutive issues with tags 0..7, out_ready=1 -> in_ready stays 1; tags 0..7 emerge in cycles t+3..t+10 in order.
- Backpressure: out_ready=0 with 5 issue attempts -> in_ready=0 after the 4th accept; the 5th waits. out_ready=1 releases tags 0..3 on consecutive cycles; the 5th is accepted once occ<4 and emerges last.
- Full with simultaneous push/pop: FIFO at 3 entries plus 1 in flight, out_ready=1 for one cycle -> count stays 4-1+1 correctly, no assertion, order preserved.
- Reset mid-op: 2 ops in flight plus 2 buffered, rst pulsed for 1 cycle -> out_valid=0 next cycle; no stale result ever appears; in_ready=1 after the rst release.
- Sticky (macro defined): pipe model drives pipe_ovf=1 for tag 6 -> ovf_sticky=1 after its pop and stays 1; ovf_clr=1 -> 0 next cycle. With the macro undefined -> ovf_sticky is constantly 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP unit definitions: data width, add/sub pipe latency, tag width and the
// retired-result record.
package fpu_pkg;

  localparam int FLEN               = 32;
  localparam int FPU_ADDSUB_LATENCY = 2;
  localparam int FPU_TAGW           = 5;

  typedef struct packed {
    logic                ovf;
    logic [FPU_TAGW-1:0] tag;
    logic [FLEN-1:0]     data;
  } fpu_result_t;

endpackage

// File: rtl/fpu_retire_fifo.sv
// Synchronous FIFO with registered storage. The head entry is read straight out of
// the storage array, so a push into an empty FIFO is visible on the following cycle.
module fpu_retire_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  overflow_check: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/fpu_pipe_retire.sv
// Retire stage behind the fixed-latency FP add/sub pipe: issue credit, tag tracking
// and an in-order result FIFO. Define FPU_RETIRE_STICKY_OVF_EN for the sticky overflow flag.
module fpu_pipe_retire
  import fpu_pkg::*;
#(
  parameter int LATENCY = FPU_ADDSUB_LATENCY,
  parameter int TAGW    = FPU_TAGW,
  parameter int DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TAGW-1:0] in_tag,
  input  logic [31:0]     pipe_y,
  input  logic            pipe_ovf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic            out_ovf,
  output logic [TAGW-1:0] out_tag,
  output logic            ovf_sticky,
  input  logic            ovf_clr
);

  localparam int RW = 1 + TAGW + FLEN;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(LATENCY + DEPTH + 1);

  logic [LATENCY-1:0] vld_sr;
  logic [TAGW-1:0]    tag_sr [LATENCY];
  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [OW-1:0]      inflight;
  logic [OW-1:0]      occ;
  logic [RW-1:0]      push_data;
  logic [RW-1:0]      head;

  assign accept    = in_valid && in_ready;
  assign push      = vld_sr[LATENCY-1];
  assign push_data = {pipe_ovf, tag_sr[LATENCY-1], pipe_y};

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + OW'(vld_sr[i]);
    end
  end

  // Every accepted op already owns a FIFO slot, so a pipe result can never be dropped.
  assign occ      = inflight + OW'(fifo_count);
  assign in_ready = !rst && (occ < OW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_sr[i] <= '0;
      end
    end else begin
      vld_sr[0] <= accept;
      tag_sr[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  fpu_retire_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid                     = !fifo_empty;
  assign pop                           = out_valid && out_ready;
  assign {out_ovf, out_tag, out_data}  = head;

  no_drop_check: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

`ifdef FPU_RETIRE_STICKY_OVF_EN
  // A retiring overflow takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (pop && out_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_pipe_retire.sv
// Self-checking bench for fpu_pipe_retire: a stand-in 2-stage pipe, a scoreboard of
// issued results, and directed latency, credit, reset and sticky-flag checks.
module tb_fpu_pipe_retire;
  import fpu_pkg::*;

`ifdef FPU_RETIRE_STICKY_OVF_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [FPU_TAGW-1:0] in_tag;
  logic [FLEN-1:0]     pipe_y;
  logic                pipe_ovf;
  logic                out_valid;
  logic                out_ready;
  logic [FLEN-1:0]     out_data;
  logic                out_ovf;
  logic [FPU_TAGW-1:0] out_tag;
  logic                ovf_sticky;
  logic                ovf_clr;

  logic [FLEN-1:0]     issue_y;
  logic                issue_ovf;
  logic [FLEN-1:0]     st1_y, st2_y;
  logic                st1_ovf, st2_ovf;

  int                  cyc = 0;
  int                  n_checks = 0;
  int                  n_pass = 0;
  fpu_result_t         sb_q[$];
  fpu_result_t         push_e;
  fpu_result_t         exp_e;
  fpu_result_t         held;
  logic                held_valid = 1'b0;
  int                  t0, c0;

  fpu_pipe_retire dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tag     (in_tag),
    .pipe_y     (pipe_y),
    .pipe_ovf   (pipe_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .out_tag    (out_tag),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the add/sub pipe: carries a precomputed result, junk when idle.
  always @(posedge clk) begin
    st1_y   <= in_valid ? issue_y : $urandom();
    st1_ovf <= in_valid ? issue_ovf : 1'($urandom_range(0, 1));
    st2_y   <= st1_y;
    st2_ovf <= st1_ovf;
  end
  assign pipe_y   = st2_y;
  assign pipe_ovf = st2_ovf;

  always @(posedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else if (in_valid && in_ready) begin
      push_e = {issue_ovf, in_tag, issue_y};
      sb_q.push_back(push_e);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Retired results must match issue order; stalled outputs must hold.
  always @(negedge clk) begin
    if (rst) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_data", 64'({out_ovf, out_tag, out_data}), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("stray_result", 64'd1, 64'd0);
        end else begin
          exp_e = sb_q.pop_front();
          checkOutput("ret_data", 64'(out_data), 64'(exp_e.data));
          checkOutput("ret_tag", 64'(out_tag), 64'(exp_e.tag));
          checkOutput("ret_ovf", 64'(out_ovf), 64'(exp_e.ovf));
        end
      end
      held_valid = out_valid && !out_ready;
      held       = {out_ovf, out_tag, out_data};
    end
  end

  task automatic applyStimulus(input logic v, input logic [FPU_TAGW-1:0] t,
                               input logic [FLEN-1:0] y, input logic o);
    in_valid  = v;
    in_tag    = t;
    issue_y   = y;
    issue_ovf = o;
    @(posedge clk); #1;
  endtask

  task automatic issueOp(input logic [FPU_TAGW-1:0] t, input logic [FLEN-1:0] y, input logic o);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      in_valid  = 1'b1;
      in_tag    = t;
      issue_y   = y;
      issue_ovf = o;
      acc       = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) checkOutput("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitPos(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic atNeg(input int n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cyc < n && k < 1000);
    if (cyc != n) checkOutput("schedule", 64'(cyc), 64'(n));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_tag = '0; issue_y = '0; issue_ovf = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
    checkOutput("rst_sticky", 64'(ovf_sticky), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Single op, accepted in cycle 10: fsub 3.0 - 1.0 = 2.0
    waitPos(10);
    checkOutput("single_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 5'd3, 32'h4000_0000, 1'b0);
    in_valid = 1'b0;
    atNeg(11); checkOutput("single_v11", 64'(out_valid), 64'd0);
    atNeg(12); checkOutput("single_v12", 64'(out_valid), 64'd0);
    atNeg(13);
    checkOutput("single_v13", 64'(out_valid), 64'd1);
    checkOutput("single_data", 64'(out_data), 64'h4000_0000);
    checkOutput("single_tag", 64'(out_tag), 64'd3);
    checkOutput("single_ovf", 64'(out_ovf), 64'd0);
    atNeg(14); checkOutput("single_v14", 64'(out_valid), 64'd0);

    // Back-to-back issue at full rate
    waitPos(20);
    t0 = cyc;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          checkOutput("b2b_in_ready", 64'(in_ready), 64'd1);
          applyStimulus(1'b1, 5'(i), 32'h1000_0000 + 32'(i), (i == 5));
        end
        in_valid = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        atNeg(t0 + 3 + i);
        checkOutput("b2b_valid", 64'(out_valid), 64'd1);
        checkOutput("b2b_tag", 64'(out_tag), 64'(i));
      end
    join
    waitPos(t0 + 14);

    // Backpressure: four accepts fill the credit, the fifth waits
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issueOp(5'(i), 32'h2000_0000 + 32'(i), 1'b0);
    in_valid = 1'b1; in_tag = 5'd4; issue_y = 32'h2000_0004; issue_ovf = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    c0 = cyc;
    out_ready = 1'b1;
    fork
      issueOp(5'd4, 32'h2000_0004, 1'b0);
      for (int i = 0; i < 5; i++) begin
        atNeg(c0 + i);
        checkOutput("bp_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_tag", 64'(out_tag), 64'(i));
      end
    join
    waitPos(c0 + 8);

    // Occupancy at the credit limit with a simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(10 + i), 32'h3000_0000 + 32'(i), 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_valid", 64'(out_valid), 64'd1);
    checkOutput("full_head_tag", 64'(out_tag), 64'd10);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("full_after_ready", 64'(in_ready), 64'd1);
    checkOutput("full_after_tag", 64'(out_tag), 64'd11);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) applyStimulus(1'b0, '0, '0, 1'b0);

    // Reset with two ops in flight and two buffered
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(20 + i), 32'h5000_0000 + 32'(i), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("midrst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Sticky overflow flag
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("sticky_clear0", 64'(ovf_sticky), 64'd0);
    @(posedge clk); #1;
    t0 = cyc;
    applyStimulus(1'b1, 5'd5, 32'h4100_0000, 1'b0);
    applyStimulus(1'b1, 5'd6, 32'h7F80_0000, 1'b1);
    in_valid = 1'b0;
    atNeg(t0 + 3); checkOutput("sticky_pre5", 64'(ovf_sticky), 64'd0);
    atNeg(t0 + 4); checkOutput("sticky_pre6", 64'(ovf_sticky), 64'd0);
    for (int i = 5; i < 9; i++) begin
      atNeg(t0 + i);
      checkOutput("sticky_set", 64'(ovf_sticky), 64'(STICKY_ON));
    end
    waitPos(t0 + 9);
    ovf_clr = 1'b1;
    @(negedge clk);
    checkOutput("sticky_clr_pending", 64'(ovf_sticky), 64'(STICKY_ON));
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("sticky_cleared", 64'(ovf_sticky), 64'd0);
    @(posedge clk); #1;

    // Clear coinciding with a setting pop: the set wins
    t0 = cyc;
    applyStimulus(1'b1, 5'd7, 32'h0000_0001, 1'b1);
    in_valid = 1'b0;
    waitPos(t0 + 3);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("sticky_set_wins", 64'(ovf_sticky), 64'(STICKY_ON));

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
